// File: rtl/ahb_slave_if.sv
// AHB-Lite slave-side bundle: address/data phase inputs, response and the registered data-phase view for the glue.
interface ahb_slave_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hready;
    logic [31:0] hwdata;
    logic        glue_hresp;
    logic        hreadyout;
    logic        hresp;
    logic        dp_valid;
    logic [31:0] dp_haddr;
    logic        dp_hwrite;
    logic [2:0]  dp_hsize;
    logic [3:0]  dp_hprot;
    logic [31:0] dp_hwdata;

    modport slave (
        input  hsel, htrans, haddr, hwrite, hsize, hprot, hready, hwdata, glue_hresp,
        output hreadyout, hresp, dp_valid, dp_haddr, dp_hwrite, dp_hsize, dp_hprot, dp_hwdata
    );

    modport master (
        output hsel, htrans, haddr, hwrite, hsize, hprot, hready, hwdata, glue_hresp,
        input  hreadyout, hresp, dp_valid, dp_haddr, dp_hwrite, dp_hsize, dp_hprot, dp_hwdata
    );
endinterface

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite data-phase controller: aligns address-phase controls with HWDATA, adds read wait states
// and produces the two-cycle ERROR response; dp_valid is the only commit strobe seen by the glue.
//   state  | meaning
//   S_IDLE | no transfer in data phase, ready
//   S_DPH  | first data-phase cycle of an accepted transfer
//   S_WAIT | read wait states, counting down
//   S_ERR2 | second cycle of the ERROR response
module ahb_slave_ctrl #(
    parameter int RD_WAIT   = 1,
    parameter int CHK_ALIGN = 1
) (
    input  logic        i_hclk,
    input  logic        i_hrst,
    ahb_slave_if.slave  bus
);
    localparam int CW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DPH, S_WAIT, S_ERR2} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mis;
    logic [31:0]   r_dp_haddr;
    logic          r_dp_hwrite;
    logic [2:0]    r_dp_hsize;
    logic [3:0]    r_dp_hprot;

    logic w_accept;
    logic w_mis_new;
    logic w_ready;
    logic w_resp;
    logic w_valid;
    logic w_err;
    logic w_unused;

    assign w_accept  = bus.hsel & bus.hready & bus.htrans[1];
    assign w_mis_new = (CHK_ALIGN != 0) &
                       (((bus.hsize == 3'd1) & bus.haddr[0]) |
                        ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00)));
    assign w_unused  = bus.htrans[0];

    // The glue's error is computed from dp_* in the same cycle, so the response has to be combinational.
    always_comb begin
        w_ready = 1'b1;
        w_resp  = 1'b0;
        w_valid = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_DPH: begin
                if (r_mis | bus.glue_hresp) begin
                    w_err   = 1'b1;
                    w_ready = 1'b0;
                    w_resp  = 1'b1;
                end else if (r_dp_hwrite || (RD_WAIT == 0)) begin
                    w_valid = 1'b1;
                end else begin
                    w_ready = 1'b0;
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) w_ready = 1'b0;
                else             w_valid = 1'b1;
            end
            S_ERR2:  w_resp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hrst) begin
        if (i_hrst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mis       <= 1'b0;
            r_dp_haddr  <= '0;
            r_dp_hwrite <= 1'b0;
            r_dp_hsize  <= '0;
            r_dp_hprot  <= '0;
        end else if (w_ready && w_accept) begin
            r_state     <= S_DPH;
            r_mis       <= w_mis_new;
            r_dp_haddr  <= bus.haddr;
            r_dp_hwrite <= bus.hwrite;
            r_dp_hsize  <= bus.hsize;
            r_dp_hprot  <= bus.hprot;
        end else begin
            case (r_state)
                S_DPH: begin
                    if (w_err) begin
                        r_state <= S_ERR2;
                    end else if (!w_ready) begin
                        r_cnt   <= CW'(RD_WAIT - 1);
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
                    else             r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hreadyout = w_ready;
    assign bus.hresp     = w_resp;
    assign bus.dp_valid  = w_valid;
    assign bus.dp_haddr  = r_dp_haddr;
    assign bus.dp_hwrite = r_dp_hwrite;
    assign bus.dp_hsize  = r_dp_hsize;
    assign bus.dp_hprot  = r_dp_hprot;
    assign bus.dp_hwdata = bus.hwdata;
endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Bench for ahb_slave_ctrl: three instances (RD_WAIT=2/CHK=1, RD_WAIT=0/CHK=1, RD_WAIT=0/CHK=0) share one stimulus.
module tb_ahb_slave_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_hsel = 1'b0;
    logic [1:0]  s_htrans = 2'b00;
    logic [31:0] s_haddr = '0;
    logic        s_hwrite = 1'b0;
    logic [2:0]  s_hsize = 3'd2;
    logic [3:0]  s_hprot = 4'h3;
    logic [31:0] s_hwdata = '0;

    logic [2:0]       o_ready, o_resp, o_valid, o_wr;
    logic [2:0][31:0] o_addr, o_wdata;
    logic [2:0][2:0]  o_size;
    logic [2:0][3:0]  o_prot;

    ahb_slave_if bus[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].hsel       = s_hsel;
        assign bus[g].htrans     = s_htrans;
        assign bus[g].haddr      = s_haddr;
        assign bus[g].hwrite     = s_hwrite;
        assign bus[g].hsize      = s_hsize;
        assign bus[g].hprot      = s_hprot;
        assign bus[g].hwdata     = s_hwdata;
        assign bus[g].hready     = bus[g].hreadyout;
        // Glue rejects writes into the ROM window 0xAxxx_xxxx.
        assign bus[g].glue_hresp = bus[g].dp_hwrite && (bus[g].dp_haddr[31:28] == 4'hA);

        ahb_slave_ctrl #(.RD_WAIT(g == 0 ? 2 : 0), .CHK_ALIGN(g == 2 ? 0 : 1)) u_dut (
            .i_hclk (clk),
            .i_hrst (rst),
            .bus    (bus[g])
        );

        assign o_ready[g] = bus[g].hreadyout;
        assign o_resp[g]  = bus[g].hresp;
        assign o_valid[g] = bus[g].dp_valid;
        assign o_addr[g]  = bus[g].dp_haddr;
        assign o_wr[g]    = bus[g].dp_hwrite;
        assign o_size[g]  = bus[g].dp_hsize;
        assign o_prot[g]  = bus[g].dp_hprot;
        assign o_wdata[g] = bus[g].dp_hwdata;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h at %0t", name, idx, got, want, $time);
    endtask

    function automatic int rdw(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit chk(input int i);
        return i != 2;
    endfunction

    // Model: an in-flight transfer with its remaining data-phase cycles, plus an error-tail flag.
    bit          m_act[3], m_first[3], m_err2[3], m_mis[3], m_wr[3];
    int          m_rem[3];
    logic [31:0] m_addr[3];
    logic [2:0]  m_size[3];
    logic [3:0]  m_prot[3];

    function automatic void exp_out(input int i, output bit rdy, output bit rsp, output bit vld);
        rdy = 1'b1; rsp = 1'b0; vld = 1'b0;
        if (m_err2[i]) begin
            rsp = 1'b1;
        end else if (m_act[i]) begin
            if (m_first[i] && (m_mis[i] || (m_wr[i] && m_addr[i][31:28] == 4'hA))) begin
                rdy = 1'b0; rsp = 1'b1;
            end else if (m_rem[i] == 1) begin
                vld = 1'b1;
            end else begin
                rdy = 1'b0;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i] <= 0; m_first[i] <= 0; m_err2[i] <= 0; m_mis[i] <= 0; m_wr[i] <= 0;
                m_rem[i] <= 0; m_addr[i] <= '0; m_size[i] <= '0; m_prot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin : upd
                bit rdy, rsp, vld;
                exp_out(i, rdy, rsp, vld);
                m_err2[i] <= 1'b0;
                if (m_act[i] && !rdy && rsp) begin
                    m_err2[i] <= 1'b1;
                    m_act[i]  <= 1'b0;
                end else if (m_act[i]) begin
                    if (vld) m_act[i] <= 1'b0;
                    else begin
                        m_rem[i]   <= m_rem[i] - 1;
                        m_first[i] <= 1'b0;
                    end
                end
                if (rdy && s_hsel && s_htrans[1]) begin
                    m_act[i]   <= 1'b1;
                    m_first[i] <= 1'b1;
                    m_rem[i]   <= s_hwrite ? 1 : rdw(i) + 1;
                    m_addr[i]  <= s_haddr;
                    m_wr[i]    <= s_hwrite;
                    m_size[i]  <= s_hsize;
                    m_prot[i]  <= s_hprot;
                    m_mis[i]   <= chk(i) && ((s_hsize == 3'd1 && s_haddr[0]) ||
                                             (s_hsize == 3'd2 && s_haddr[1:0] != 2'b00));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < 3; i++) begin : cmp
                bit rdy, rsp, vld;
                exp_out(i, rdy, rsp, vld);
                check("hreadyout", i, {31'd0, o_ready[i]}, {31'd0, rdy});
                check("hresp", i, {31'd0, o_resp[i]}, {31'd0, rsp});
                check("dp_valid", i, {31'd0, o_valid[i]}, {31'd0, vld});
                check("dp_haddr", i, o_addr[i], m_addr[i]);
                check("dp_hwrite", i, {31'd0, o_wr[i]}, {31'd0, m_wr[i]});
                check("dp_hsize", i, {29'd0, o_size[i]}, {29'd0, m_size[i]});
                check("dp_hprot", i, {28'd0, o_prot[i]}, {28'd0, m_prot[i]});
                check("dp_hwdata", i, o_wdata[i], s_hwdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = addr; s_hwrite = wr; s_hsize = size;
    endtask

    task automatic idle();
        s_hsel = 1'b0; s_htrans = 2'b00;
    endtask

    initial begin
        logic [2:0] rseq, vseq;
        int pulses;
        rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_hreadyout", i, {31'd0, o_ready[i]}, 32'd1);
            check("rst_hresp", i, {31'd0, o_resp[i]}, 32'd0);
            check("rst_dp_valid", i, {31'd0, o_valid[i]}, 32'd0);
            check("rst_dp_haddr", i, o_addr[i], 32'd0);
        end
        rst = 1'b0;
        tick();

        // single write
        drive(32'h0000_0010, 1'b1, 3'd2);
        tick();
        idle(); s_hwdata = 32'hDEAD_BEEF;
        #1;
        check("wr_dp_valid", 1, {31'd0, o_valid[1]}, 32'd1);
        check("wr_dp_hwrite", 1, {31'd0, o_wr[1]}, 32'd1);
        check("wr_dp_hwdata", 1, o_wdata[1], 32'hDEAD_BEEF);
        check("wr_hreadyout", 1, {31'd0, o_ready[1]}, 32'd1);
        check("wr_hresp", 1, {31'd0, o_resp[1]}, 32'd0);
        check("wr_dp_valid", 0, {31'd0, o_valid[0]}, 32'd1);
        repeat (3) tick();

        // read with two wait states on dut0
        drive(32'hA000_0004, 1'b0, 3'd2);
        tick();
        idle();
        #1;
        rseq[2] = o_ready[0]; vseq[2] = o_valid[0];
        check("rd0_dp_valid", 1, {31'd0, o_valid[1]}, 32'd1);
        tick();
        rseq[1] = o_ready[0]; vseq[1] = o_valid[0];
        tick();
        rseq[0] = o_ready[0]; vseq[0] = o_valid[0];
        check("rd_ready_seq", 0, {29'd0, rseq}, 32'b001);
        check("rd_valid_seq", 0, {29'd0, vseq}, 32'b001);
        check("rd_dp_haddr", 0, o_addr[0], 32'hA000_0004);
        repeat (3) tick();

        // write into ROM -> two-cycle ERROR
        drive(32'hA000_0000, 1'b1, 3'd2);
        tick();
        idle();
        #1;
        check("rom_dph_ready", 0, {31'd0, o_ready[0]}, 32'd0);
        check("rom_dph_resp", 0, {31'd0, o_resp[0]}, 32'd1);
        check("rom_dph_valid", 1, {31'd0, o_valid[1]}, 32'd0);
        tick();
        check("rom_err2_ready", 0, {31'd0, o_ready[0]}, 32'd1);
        check("rom_err2_resp", 0, {31'd0, o_resp[0]}, 32'd1);
        check("rom_err2_valid", 0, {31'd0, o_valid[0]}, 32'd0);
        tick();
        check("rom_after_resp", 0, {31'd0, o_resp[0]}, 32'd0);
        repeat (2) tick();

        // misaligned word read: ERROR with alignment check, OKAY without
        drive(32'h0000_0002, 1'b0, 3'd2);
        tick();
        idle();
        #1;
        check("mis_dph_ready", 1, {31'd0, o_ready[1]}, 32'd0);
        check("mis_dph_resp", 1, {31'd0, o_resp[1]}, 32'd1);
        check("mis_nochk_valid", 2, {31'd0, o_valid[2]}, 32'd1);
        check("mis_nochk_resp", 2, {31'd0, o_resp[2]}, 32'd0);
        tick();
        check("mis_err2_ready", 1, {31'd0, o_ready[1]}, 32'd1);
        check("mis_err2_resp", 1, {31'd0, o_resp[1]}, 32'd1);
        repeat (3) tick();

        // back-to-back write then read of 0x20
        drive(32'h0000_0020, 1'b1, 3'd2);
        tick();
        drive(32'h0000_0020, 1'b0, 3'd2); s_hwdata = 32'h1234_5678;
        #1;
        check("b2b_wr_valid", 1, {31'd0, o_valid[1]}, 32'd1);
        check("b2b_wr_hwrite", 1, {31'd0, o_wr[1]}, 32'd1);
        check("b2b_wr_ready", 1, {31'd0, o_ready[1]}, 32'd1);
        tick();
        idle();
        #1;
        check("b2b_rd_valid", 1, {31'd0, o_valid[1]}, 32'd1);
        check("b2b_rd_hwrite", 1, {31'd0, o_wr[1]}, 32'd0);
        check("b2b_rd_haddr", 1, o_addr[1], 32'h0000_0020);
        check("b2b_rd_ready", 1, {31'd0, o_ready[1]}, 32'd1);
        repeat (4) tick();

        // transfer accepted during the ERROR tail
        drive(32'hA000_0008, 1'b1, 3'd2);
        tick();
        idle();
        tick();
        drive(32'h0000_0030, 1'b0, 3'd2); s_hprot = 4'hA;
        tick();
        idle();
        #1;
        check("err2_acc_valid", 1, {31'd0, o_valid[1]}, 32'd1);
        check("err2_acc_haddr", 1, o_addr[1], 32'h0000_0030);
        check("err2_acc_hprot", 1, {28'd0, o_prot[1]}, 32'hA);
        repeat (4) tick();

        // reset asserted while dut0 is in read wait states
        drive(32'h0000_0040, 1'b0, 3'd2);
        tick();
        idle();
        tick();
        #2 rst = 1'b1;
        #1;
        check("rstw_hreadyout", 0, {31'd0, o_ready[0]}, 32'd1);
        check("rstw_hresp", 0, {31'd0, o_resp[0]}, 32'd0);
        check("rstw_dp_valid", 0, {31'd0, o_valid[0]}, 32'd0);
        check("rstw_dp_haddr", 0, o_addr[0], 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(o_valid[0]);
        end
        check("rstw_no_commit", 0, pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ahb_slave_ctrl.md
Name: ahb_slave_ctrl

Overview:
- AHB-Lite data-phase controller between the bus interconnect and the combinational ROM/RAM slave glue.
- Registers address-phase controls so they align with HWDATA in the data phase.
- Inserts read wait states for synchronous memories and drives the two-cycle AHB ERROR response.
- Sole source of HREADYOUT/HRESP to the master; it gates all glue enables through a single-cycle commit strobe.

Parameters:
RD_WAIT, 1, read wait states inserted before read data is valid (0..15)
CHK_ALIGN, 1, when 1, a misaligned halfword/word transfer returns ERROR

Ports:
hclk  input  1  system clock
hrst  input  1  reset, asynchronous, active-high
hsel  input  1  slave select from the decoder
htrans  input  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
haddr  input  32  address-phase address
hwrite  input  1  address-phase direction
hsize  input  3  address-phase size (0 byte, 1 half, 2 word)
hprot  input  4  address-phase protection
hready  input  1  bus-level HREADY (previous transfer complete)
hwdata  input  32  write data, valid in the data phase
glue_hresp  input  1  error request from the glue, computed from dp_* (OR of inst/data hresp)
hreadyout  output  1  slave ready to master
hresp  output  1  slave response to master (0 OKAY, 1 ERROR)
dp_valid  output  1  one-cycle commit strobe; the glue qualifies wr_en/rd_en with it
dp_haddr  output  32  registered address
dp_hwrite  output  1  registered direction
dp_hsize  output  3  registered size
dp_hprot  output  4  registered protection
dp_hwdata  output  32  equals hwdata, passed through combinationally

Behaviour:
- Accept condition: hsel & hready & htrans[1]. On accept, capture haddr/hwrite/hsize/hprot into dp_* and set mis = CHK_ALIGN & ((hsize==1 & haddr[0]) | (hsize==2 & haddr[1:0]!=0)).
- Next state is DPH on accept, otherwise IDLE.
- IDLE/BUSY transfers while selected: no state change, OKAY response.
- Reset (async, any state, including mid-transfer):
  - state IDLE, counter 0, mis 0;
  - hreadyout=1, hresp=0, dp_valid=0;
  - all dp_* registers 0.
  - An interrupted transfer never produces a dp_valid pulse.
- IDLE: hreadyout=1, hresp=0, dp_valid=0.
- DPH (first data-phase cycle), evaluated in priority order:
  1. mis | glue_hresp: hreadyout=0, hresp=1, dp_valid=0; go to ERR2.
  2. Write, or read with RD_WAIT==0: hreadyout=1, hresp=0, dp_valid=1; this cycle may accept the next transfer (back-to-back, go to DPH) or go to IDLE.
  3. Read with RD_WAIT>0: hreadyout=0, dp_valid=0; load cnt=RD_WAIT-1; go to WAIT.
- WAIT:
  - cnt>0: hreadyout=0; decrement cnt.
  - cnt==0: hreadyout=1, hresp=0, dp_valid=1; accept next transfer as in DPH.
- ERR2: hreadyout=1, hresp=1, dp_valid=0. A transfer accepted here goes to DPH. The master may also drive IDLE to cancel.
- Latency:
  - write: one data-phase cycle;
  - read: RD_WAIT+1 data-phase cycles;
  - error: exactly two cycles.
- Ordering: a write commits in its data phase; a following read's DPH sees the already-written data.
- Address-phase signals arriving while hreadyout=0 are ignored; they are captured only on accept.
- dp_* hold their values after a transfer until the next accept.
- Counter width is $clog2(RD_WAIT+1); it must be sized so it never wraps.

Test Plan:
- Reset with hrst asserted mid-WAIT -> same cycle: hreadyout=1, hresp=0, dp_valid=0, dp_haddr=0; no commit after release.
- Single word write haddr=0x0000_0010, hwdata=0xDEAD_BEEF -> next cycle: dp_valid=1, dp_hwrite=1, dp_hwdata=0xDEAD_BEEF, hreadyout=1, hresp=0.
- Read haddr=0xA000_0004 with RD_WAIT=2 -> hreadyout 0,0,1 across three data cycles; dp_valid=1 only in the third.
- Write to ROM (haddr=0xA000_0000, glue_hresp=1) -> DPH: hreadyout=0/hresp=1; ERR2: hreadyout=1/hresp=1; dp_valid never asserted.
- Misaligned word read haddr=0x0000_0002, hsize=2 -> two-cycle ERROR; repeat with CHK_ALIGN=0 -> OKAY.
- Back-to-back NONSEQ write 0x20 then read 0x20, RD_WAIT=0 -> dp_valid high two consecutive cycles; read dp_haddr=0x20; hreadyout stays 1.
